// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory port between the core load/store
// path (requester 0) and a DMA/loader (requester 1), with a single registered command stage.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SIZE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SIZE_W-1:0] m0_size,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SIZE_W-1:0] m1_size,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              d_we,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dwdata,
  output logic [SIZE_W-1:0] size_control,
  input  logic [DATA_W-1:0] drdata
);

  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_owner_q, cmd_owner_d;
  logic              last_gnt_q,  last_gnt_d;
  logic              cmd_we_q,    cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
  logic [SIZE_W-1:0] cmd_size_q,  cmd_size_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              gnt0, gnt1;
  logic              live;

  // Arbitration: on contention the requester that did not win last time goes.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (last_gnt_q) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Command stage next state: fields hold when nothing is accepted.
  always_comb begin
    cmd_valid_d = gnt0 | gnt1;
    cmd_owner_d = cmd_owner_q;
    last_gnt_d  = last_gnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_size_d  = cmd_size_q;
    cmd_wdata_d = cmd_wdata_q;
    if (gnt0) begin
      cmd_owner_d = 1'b0;
      last_gnt_d  = 1'b0;
      cmd_we_d    = m0_we;
      cmd_addr_d  = m0_addr;
      cmd_size_d  = m0_size;
      cmd_wdata_d = m0_wdata;
    end else if (gnt1) begin
      cmd_owner_d = 1'b1;
      last_gnt_d  = 1'b1;
      cmd_we_d    = m1_we;
      cmd_addr_d  = m1_addr;
      cmd_size_d  = m1_size;
      cmd_wdata_d = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_owner_q <= 1'b0;
      last_gnt_q  <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_size_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_owner_q <= cmd_owner_d;
      last_gnt_q  <= last_gnt_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_size_q  <= cmd_size_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  // An in-flight command is killed the moment reset asserts, so no write lands.
  always_comb begin
    live         = cmd_valid_q & ~rst;
    d_we         = live & cmd_we_q;
    daddr        = live ? cmd_addr_q  : '0;
    dwdata       = live ? cmd_wdata_q : '0;
    size_control = live ? cmd_size_q  : '0;
    m0_rvalid    = live & ~cmd_we_q & ~cmd_owner_q;
    m1_rvalid    = live & ~cmd_we_q &  cmd_owner_q;
    m0_rdata     = m0_rvalid ? drdata : '0;
    m1_rdata     = m1_rvalid ? drdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory attached.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [SIZE_W-1:0] m0_size, m1_size;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              d_we;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dwdata, drdata;
  logic [SIZE_W-1:0] size_control;

  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] mem [0:31];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .d_we(d_we), .daddr(daddr), .dwdata(dwdata), .size_control(size_control),
    .drdata(drdata)
  );

  // Memory model: combinational read, write at the clock edge.
  assign drdata = mem[daddr];
  always @(posedge clk) begin
    if (ld_en)     mem[ld_addr] <= ld_data;
    else if (d_we) mem[daddr]   <= dwdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5; m0_size = 3'd2; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd1; m1_size = 3'd2; m1_wdata = '0;
    preload(5'd5, 32'hDEADBEEF);
    preload(5'd9, 32'h00000055);
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b exp 00", {m0_gnt, m1_gnt});
    end
    checks++;
    if ({d_we, daddr, dwdata, size_control, m0_rvalid, m1_rvalid} !== '0) begin
      errors++; $display("FAIL reset_outputs d_we=%b daddr=%h dwdata=%h size=%h rv=%b%b exp all 0",
                         d_we, daddr, dwdata, size_control, m0_rvalid, m1_rvalid);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL single_read_gnt got %b exp 10", {m0_gnt, m1_gnt});
    end
    step();
    m0_req = 1'b0;
    #1;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_read_data rvalid=%b rdata=%h exp 1 deadbeef", m0_rvalid, m0_rdata);
    end
    checks++;
    if (m1_rvalid !== 1'b0 || d_we !== 1'b0 || daddr !== 5'd5) begin
      errors++; $display("FAIL single_read_port m1_rvalid=%b d_we=%b daddr=%h exp 0 0 05",
                         m1_rvalid, d_we, daddr);
    end
    step();
  endtask

  task automatic test_contention();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 5'd3; m0_wdata = 32'h11;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd4; m1_wdata = 32'h22;
    for (int i = 0; i < 6; i++) begin
      logic exp0;
      exp0 = (i % 2 == 0);
      #1;
      checks++;
      if ({m0_gnt, m1_gnt} !== {exp0, ~exp0}) begin
        errors++; $display("FAIL contention_gnt cycle %0d got %b exp %b", i, {m0_gnt, m1_gnt}, {exp0, ~exp0});
      end
      step();
      checks++;
      if (d_we !== 1'b1 || daddr !== (exp0 ? 5'd3 : 5'd4)) begin
        errors++; $display("FAIL contention_drive cycle %0d d_we=%b daddr=%h exp 1 %h",
                           i, d_we, daddr, exp0 ? 5'd3 : 5'd4);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    checks++;
    if (mem[3] !== 32'h11 || mem[4] !== 32'h22) begin
      errors++; $display("FAIL contention_mem mem3=%h mem4=%h exp 11 22", mem[3], mem[4]);
    end
  endtask

  task automatic test_raw();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd7; m1_size = 3'b010; m1_wdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++; $display("FAIL raw_write_gnt got %b exp 1", m1_gnt);
    end
    step();
    m1_we = 1'b0;
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || d_we !== 1'b1 || daddr !== 5'd7 || size_control !== 3'b010 ||
        dwdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL raw_write_drive gnt=%b d_we=%b daddr=%h size=%h dwdata=%h exp 1 1 07 2 cafef00d",
                         m1_gnt, d_we, daddr, size_control, dwdata);
    end
    step();
    m1_req = 1'b0;
    #1;
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hCAFEF00D || m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL raw_read m1_rvalid=%b m1_rdata=%h m0_rvalid=%b exp 1 cafef00d 0",
                         m1_rvalid, m1_rdata, m0_rvalid);
    end
    step();
  endtask

  task automatic test_idle();
    m0_req = 1'b0; m1_req = 1'b0;
    m0_we = 1'bx; m0_addr = 'x; m0_wdata = 'x; m0_size = 'x;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++; $display("FAIL idle_gnt got %b exp 00", {m0_gnt, m1_gnt});
    end
    step();
    step();
    checks++;
    if ({d_we, daddr, dwdata, size_control, m0_rvalid, m1_rvalid} !== '0 ||
        m0_rdata !== '0 || m1_rdata !== '0) begin
      errors++; $display("FAIL idle_outputs d_we=%b daddr=%h dwdata=%h size=%h rv=%b%b exp all 0",
                         d_we, daddr, dwdata, size_control, m0_rvalid, m1_rvalid);
    end
  endtask

  task automatic test_streaming();
    int gnts = 0;
    int rvs  = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5; m0_size = 3'd2; m0_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (m0_gnt === 1'b1) gnts++;
      step();
      if (i == 3) m0_req = 1'b0;
      #1;
      if (m0_rvalid === 1'b1 && m0_rdata === 32'hDEADBEEF) rvs++;
    end
    checks++;
    if (gnts !== 4) begin
      errors++; $display("FAIL stream_gnts got %0d exp 4", gnts);
    end
    checks++;
    if (rvs !== 4) begin
      errors++; $display("FAIL stream_rvalids got %0d exp 4", rvs);
    end
    step();
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 5'd9; m1_size = 3'b010; m1_wdata = 32'hABCD1234;
    #1;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt got %b exp 1", m1_gnt);
    end
    step();
    m1_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (d_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_d_we got %b exp 0", d_we);
    end
    step();
    checks++;
    if (mem[9] !== 32'h00000055) begin
      errors++; $display("FAIL rstmid_mem got %h exp 00000055", mem[9]);
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd9;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      errors++; $display("FAIL rstmid_gnt_forced got %b exp 00", {m0_gnt, m1_gnt});
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL rstmid_first_contention got %b exp 10", {m0_gnt, m1_gnt});
    end
    step();
    m0_req = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01 || m0_rvalid !== 1'b1) begin
      errors++; $display("FAIL rstmid_second gnt=%b m0_rvalid=%b exp 01 1", {m0_gnt, m1_gnt}, m0_rvalid);
    end
    step();
    m1_req = 1'b0;
    #1;
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h00000055) begin
      errors++; $display("FAIL rstmid_read m1_rvalid=%b m1_rdata=%h exp 1 00000055", m1_rvalid, m1_rdata);
    end
    step();
  endtask

  initial begin
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_size = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_size = '0; m1_wdata = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_raw();
    test_idle();
    test_streaming();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single data memory port (d_we/daddr/dwdata/size_control/drdata) between requester 0 (rv32i_core load/store path) and requester 1 (DMA/program loader).
- Round-robin, one registered command stage, one transaction per cycle, back-to-back capable.
- Sits between the requesters and data_mem. data_mem reads are combinational and writes occur at the clock edge.

Parameters:
- ADDR_W, 5, data memory address width (matches daddr)
- DATA_W, 32, data word width
- SIZE_W, 3, access size/sign code width (funct3 encoding, passed through untouched)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- m0_req  input  1  requester 0 transaction request
- m0_we  input  1  requester 0 write (1) / read (0)
- m0_addr  input  ADDR_W  requester 0 address
- m0_size  input  SIZE_W  requester 0 size code
- m0_wdata  input  DATA_W  requester 0 write data
- m0_gnt  output  1  requester 0 command accepted this cycle
- m0_rvalid  output  1  requester 0 read data valid
- m0_rdata  output  DATA_W  requester 0 read data
- m1_req, m1_we, m1_addr, m1_size, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for requester 1
- d_we  output  1  memory write enable
- daddr  output  ADDR_W  memory address
- dwdata  output  DATA_W  memory write data
- size_control  output  SIZE_W  memory size code
- drdata  input  DATA_W  memory read data (combinational)

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - cmd_valid=0, cmd_owner=0, last_gnt=1, so requester 0 wins the first contention.
  - Command registers are 0, giving d_we=0, daddr=0, dwdata=0, size_control=0.
  - m0_rvalid=m1_rvalid=0.
- Arbitration (combinational, every cycle):
  - Only mX_req high: grant X.
  - Both high: grant the requester not equal to last_gnt.
  - Neither high: no grant.
  - mX_gnt is combinational and at most one gnt is high per cycle.
- Accept edge, on gnt to X:
  - cmd_valid<=1, cmd_owner<=X, last_gnt<=X.
  - Latch we/addr/size/wdata of X into the command registers.
- No grant: cmd_valid<=0. The command fields hold their old values, but the outputs are gated as below.
- Memory drive, cycle after accept:
  - d_we = cmd_valid & cmd_we.
  - daddr, dwdata, size_control = command registers when cmd_valid=1, else 0.
- Read return, same cycle as memory drive:
  - mX_rvalid = cmd_valid & ~cmd_we & (cmd_owner==X).
  - mX_rdata = drdata when mX_rvalid, else 0.
- Latencies:
  - Read: data 1 cycle after gnt.
  - Write: memory updated at the end of the cycle after gnt.
  - Writes produce no rvalid.
- Requester rules:
  - A requester holds req and its fields stable until it sees gnt.
  - It may drop req or issue a new request in the cycle after gnt.
- Throughput:
  - A requester holding req continuously gets gnt every cycle when alone.
  - It gets gnt every other cycle under contention.
  - Starvation bound: 1 cycle.
- Read-after-write, same address, back-to-back (write accepted cycle N, read accepted N+1): the read returns the written data at N+2. Memory commits at the end of N+1.
- Reset mid-operation:
  - A command in flight is dropped; no d_we pulse after reset asserts.
  - last_gnt returns to 1.
  - Pending requests are re-arbitrated after reset deasserts.
  - gnt is forced to 0 while rst=1.
- mX_req with X/undefined fields while req=0: ignored.

Test Plan:
- Reset, then m0 read addr 5 alone, memory word 5 = 0xDEADBEEF -> m0_gnt at cycle 1, m0_rvalid=1 and m0_rdata=0xDEADBEEF at cycle 2, m1_rvalid stays 0.
- Both request every cycle from reset: m0 write addr 3 data 0x11, m1 write addr 4 data 0x22 -> grants alternate m0,m1,m0,... starting with m0; d_we pulses every cycle; daddr alternates 3,4.
- m1 write addr 7 data 0xCAFEF00D size=SW accepted cycle N, m1 read addr 7 accepted N+1 -> m1_rdata=0xCAFEF00D with m1_rvalid at N+2.
- Idle cycles between requests -> d_we=0, daddr=0, dwdata=0, size_control=0, both rvalid=0.
- m0 holds req for 4 cycles alone -> 4 consecutive gnts, 4 consecutive rvalids.
- rst asserted the cycle after an m1 write gnt -> no d_we pulse, target word unchanged, next contention grants m0 first.
